// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam int unsigned DEFAULT_MEM_BYTES = 256;
  localparam logic [31:0] PC_INCR           = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer: push, pop, flush and entry count; head data reads 0 when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         valid,
  output logic [3:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid   = (count != 4'd0);
  assign do_push = push & ~flush;
  assign do_pop  = pop & valid & ~flush;
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + 4'(do_push) - 4'(do_pop);
    end
  end

  // Storage needs no reset: rdata is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirect handling and a fetch buffer.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirects raise sticky fetch_fault and halt fetch.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned MEM_BYTES  = DEFAULT_MEM_BYTES,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [3:0]  occupancy,
  output logic        fetch_fault
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  logic [31:0]  pc;
  logic [31:0]  target;
  logic         fault;
  logic         misaligned;
  logic         push;
  logic         pop;
  fetch_entry_t wentry;
  fetch_entry_t head;

  assign imem_addr = pc;
  assign target    = redirect_pc & ADDR_MASK & ~32'd3;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) fault <= 1'b0;
    else if (redirect_valid && misaligned) fault <= 1'b1;
  end
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  assign fetch_fault = fault;

  // A pop frees the slot the same-edge push writes into, so a full buffer can still stream.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = fetch_en & ~redirect_valid & ~fault &
                ((32'(occupancy) < 32'(FIFO_DEPTH)) | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      if (!misaligned) pc <= target;
    end else if (push) begin
      pc <= (pc + PC_INCR) & ADDR_MASK;
    end
  end

  always_comb begin
    wentry       = '0;
    wentry.pc    = pc;
    wentry.instr = imem_instr;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .rdata (head),
    .valid (out_valid),
    .count (occupancy)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: queue-based reference model, directed scenarios then random traffic.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int unsigned MEM_BYTES = 256;
  localparam int unsigned DEPTH     = 2;
  localparam int unsigned AW        = $clog2(MEM_BYTES);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [3:0]  occupancy;
  logic        fetch_fault;

  instr_fetch_ctrl #(
    .RESET_PC   (RESET_PC),
    .MEM_BYTES  (MEM_BYTES),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .occupancy      (occupancy),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_BYTES/4];
  assign imem_instr = mem[imem_addr[AW-1:2]];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] pc_m;
  bit          fault_m;
  bit          mon_en = 1'b0;
  int          tests = 0;
  int          fails = 0;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs to the model and retires the head on an accepted pop.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("imem_addr", imem_addr, pc_m);
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("fetch_fault", 32'(fetch_fault), 32'(fault_m));
      if (q.size() != 0) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_instr", out_instr, q[0].instr);
      end
      if (out_valid && out_ready && !reset && !redirect_valid && q.size() != 0)
        void'(q.pop_front());
    end
  end

  // Drives one cycle of inputs, waits the edge, then applies the model's view of that edge.
  task automatic step(input bit rst, input bit fe, input bit rdy,
                      input bit rv, input logic [31:0] rpc);
    bit will_pop, will_push;
    reset          = rst;
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    will_pop  = (q.size() != 0) && rdy;
    will_push = fe && !fault_m && ((q.size() < DEPTH) || will_pop);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      pc_m    = RESET_PC;
      fault_m = 1'b0;
    end else if (rv) begin
      q.delete();
      if (ALIGN_CHECK && rpc[1:0] != 2'b00) fault_m = 1'b1;
      else pc_m = (rpc % MEM_BYTES) & ~32'd3;
    end else if (will_push) begin
      q.push_back('{pc: pc_m, instr: mem[pc_m / 4]});
      pc_m = (pc_m + 4) % MEM_BYTES;
    end
  endtask

  task automatic run(input int n, input bit fe, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, fe, rdy, 1'b0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_BYTES / 4); i++) mem[i] = $urandom;
    mem[0] = 32'h8C08_0005;
    mem[5] = 32'h110B_0004;
    pc_m    = RESET_PC;
    fault_m = 1'b0;

    @(posedge clk); #1;
    // Reset with every other request active: reset must win.
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'd40);
    mon_en = 1'b1;
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_out_instr", out_instr, 32'd0);

    // Streaming from reset.
    run(5, 1'b1, 1'b1);

    // Back-pressure saturation, then resume.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    run(5, 1'b1, 1'b0);
    run(5, 1'b1, 1'b1);

    // Redirect while full.
    run(3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd20);
    run(4, 1'b1, 1'b1);

    // Wrap at the top of memory.
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'd248);
    run(6, 1'b1, 1'b1);

    // Redirect with fetch disabled still loads PC; fetch idles, then resumes.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'd12);
    run(3, 1'b0, 1'b1);
    run(3, 1'b1, 1'b1);

    // Misaligned redirect.
    run(2, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'd22);
    run(5, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    run(3, 1'b1, 1'b1);

    // Randomized traffic, including mid-stream resets and out-of-range targets.
    for (int i = 0; i < 3000; i++) begin
      bit          r_rst, r_fe, r_rdy, r_rv;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 149) == 0);
      r_rv  = ($urandom_range(0, 11) == 0);
      r_fe  = ($urandom_range(0, 9) < 8);
      r_rdy = ($urandom_range(0, 9) < 6);
      r_pc  = $urandom_range(0, 2 * MEM_BYTES - 1);
      if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
      step(r_rst, r_fe, r_rdy, r_rv, r_pc);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
